oci_action_sequencer: RTL and testbench
=======================================

OCI_ACTION_SEQUENCER -- requirements
Module: oci_action_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset_n  in  1  synchronous, active-low reset.
REQ-003 SHALL have: jdo  in  38  JTAG data; [17:10] address, [35] write flag, [34:3] write data.
REQ-004 SHALL have: take_action_ocimem_a  in  1  one-cycle strobe; load JTAG address.
REQ-005 SHALL have: take_action_ocimem_b  in  1  one-cycle strobe; JTAG data access.
REQ-006 SHALL have: cpu_req / cpu_we  in  1 each; cpu_addr  in  8; cpu_wdata  in  32.
REQ-007 SHALL have: cpu_ack  out  1  one-cycle completion pulse; cpu_rdata  out  32  read data, valid with cpu_ack.
REQ-008 SHALL have: ram_addr  out  8; ram_we  out  1; ram_wdata  out  32; ram_rdata  in  32  (one-cycle read latency).
REQ-009 SHALL have: MonDReg  out  32  last JTAG read data; monitor_ready  out  1  no JTAG op pending; monitor_error  out  1  sticky overrun flag.

Function
REQ-010 SHALL share one single-port debug RAM between the JTAG requester and the CPU requester.
REQ-011 SHALL load jaddr <= jdo[17:10] on take_action_ocimem_a when no JTAG op is pending.
REQ-012 SHALL set jpend on take_action_ocimem_b, latching write flag and data from jdo.
REQ-013 SHALL run FSM IDLE -> ACC -> (CAP if read) -> IDLE; a write leaves ACC straight to IDLE.
REQ-014 SHALL drive ram_addr/ram_we/ram_wdata from the granted requester only in ACC; ram_we=0 in every other state.
REQ-015 SHALL capture ram_rdata in CAP: MonDReg for JTAG reads, cpu_rdata for CPU reads.
REQ-016 SHALL timing (uncontended JTAG): strobe cycle 0; jpend=1 cycle 1; ACC cycle 2; write done and monitor_ready=1 cycle 3; read gives MonDReg valid and monitor_ready=1 cycle 4.
REQ-017 SHALL pulse cpu_ack in ACC for CPU writes and in CAP for CPU reads; cpu_req stays high until cpu_ack.
REQ-018 SHALL increment jaddr by 1 after each JTAG access, wrapping 8'hFF -> 8'h00.
REQ-019 SHALL arbitrate in IDLE: single requester is granted; if both request, grant the one not granted last.
REQ-020 SHALL drop _a or _b arriving while jpend=1 and set monitor_error; no state change.
REQ-021 SHALL, when _a and _b occur in the same cycle, load the address first; the access uses the new address.
REQ-022 SHALL hold monitor_error until the next accepted take_action_ocimem_a, which clears it.

Reset
REQ-023 SHALL, while reset_n=0 at a clock edge: FSM=IDLE, jpend=0, jaddr=0, last-grant=CPU, MonDReg=0, monitor_ready=1, monitor_error=0, cpu_ack=0, cpu_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0.
REQ-024 SHALL abort any in-flight access on reset: no ram_we pulse and no cpu_ack after reset is asserted.

Configuration
REQ-025 SHALL, with OCI_SEQ_JTAG_PRIORITY_EN defined, always grant JTAG over CPU when both request.
REQ-026 SHALL, without OCI_SEQ_JTAG_PRIORITY_EN, use the round-robin of REQ-019.

Structure
REQ-027 SHALL place the state enum, ADDR_W=8, DATA_W=32 and the jdo field positions in package oci_seq_pkg.
REQ-028 SHALL implement grant selection in the sub-module oci_seq_arb (req_j, req_c, last -> grant).

Verification
REQ-029 SHALL test: _a with jdo[17:10]=8'h10, then _b write 32'hDEADBEEF -> ram_we=1 with ram_addr=8'h10 in cycle 2; monitor_ready=1 in cycle 3.
REQ-030 SHALL test: JTAG read at 8'h10 with ram_rdata=32'hDEADBEEF -> MonDReg=32'hDEADBEEF in cycle 4; jaddr=8'h11.
REQ-031 SHALL test: jaddr=8'hFF with one access -> jaddr=8'h00.
REQ-032 SHALL test: cpu_req and JTAG pending together for 4 back-to-back ops -> grants alternate J,C,J,C; with the macro defined, both JTAG ops are granted first.
REQ-033 SHALL test: second _b during a pending read -> monitor_error=1 and only one RAM access; next _a clears it.
REQ-034 SHALL test: reset_n=0 during CAP -> no cpu_ack, FSM=IDLE, all outputs at REQ-023 values.

Source files
------------

// File: rtl/oci_seq_pkg.sv
// Shared types and constants for the OCI debug-RAM action sequencer.
// Holds the FSM state enum, the grant enum, bus widths and the jdo field positions.
package oci_seq_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int JDO_W  = 38;

  // Address and write data overlap inside jdo. Take_action_ocimem_a reads the
  // address bits and take_action_ocimem_b reads the flag and data bits.
  localparam int JDO_ADDR_LSB = 10;
  localparam int JDO_ADDR_MSB = 17;
  localparam int JDO_DATA_LSB = 3;
  localparam int JDO_DATA_MSB = 34;
  localparam int JDO_WR_BIT   = 35;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_CAP  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_JTAG = 1'b1
  } grant_e;

endpackage

// File: rtl/oci_seq_arb.sv
// Two-requester arbiter for the shared debug RAM: round-robin by default.
// Defining OCI_SEQ_JTAG_PRIORITY_EN gives JTAG fixed priority over the CPU.
module oci_seq_arb
  import oci_seq_pkg::*;
(
  input  logic   req_j,
  input  logic   req_c,
  input  grant_e last,
  output grant_e grant
);

`ifdef OCI_SEQ_JTAG_PRIORITY_EN
  logic unused_last;
  assign unused_last = last;
`endif

  // NOTE: give every always_comb output a value before any branch. A path that
  // leaves an output unassigned makes synthesis infer a latch.
  always_comb begin
    grant = GNT_CPU;
    if (req_j && req_c) begin
`ifdef OCI_SEQ_JTAG_PRIORITY_EN
      grant = GNT_JTAG;
`else
      grant = (last == GNT_CPU) ? GNT_JTAG : GNT_CPU;
`endif
    end else if (req_j) begin
      grant = GNT_JTAG;
    end
  end

endmodule

// File: rtl/oci_action_sequencer.sv
// Shares one single-port debug RAM between the JTAG monitor and a CPU port.
// Build option OCI_SEQ_JTAG_PRIORITY_EN makes JTAG win every contended grant.
module oci_action_sequencer
  import oci_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_e              state_q, state_d;
  grant_e              last_q, last_d, arb_gnt;
  logic                jpend_q, jpend_d;
  logic [ADDR_W-1:0]   jaddr_q, jaddr_d;
  logic                jwr_q, jwr_d;
  logic [DATA_W-1:0]   jwdata_q, jwdata_d;
  logic [DATA_W-1:0]   mondreg_q, mondreg_d;
  logic                err_q, err_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic req_j, req_c, a_ok, b_ok, strobe_drop;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[JDO_W-1:JDO_WR_BIT+1], jdo[JDO_DATA_LSB-1:0]};

  // The CPU keeps cpu_req high until it sees cpu_ack. Masking the ack cycle
  // stops a completed CPU request from being granted a second time.
  assign req_j       = jpend_q;
  assign req_c       = cpu_req & ~cpu_ack_q;
  assign a_ok        = take_action_ocimem_a & ~jpend_q;
  assign b_ok        = take_action_ocimem_b & ~jpend_q;
  assign strobe_drop = (take_action_ocimem_a | take_action_ocimem_b) & jpend_q;

  oci_seq_arb u_arb (
    .req_j (req_j),
    .req_c (req_c),
    .last  (last_q),
    .grant (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    jpend_d     = jpend_q;
    jaddr_d     = jaddr_q;
    jwr_d       = jwr_q;
    jwdata_d    = jwdata_q;
    mondreg_d   = mondreg_q;
    err_d       = err_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    ram_addr_d  = '0;
    ram_we_d    = 1'b0;
    ram_wdata_d = '0;

    if (a_ok) begin
      jaddr_d = jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
      err_d   = 1'b0;
    end
    if (b_ok) begin
      jpend_d  = 1'b1;
      jwr_d    = jdo[JDO_WR_BIT];
      jwdata_d = jdo[JDO_DATA_MSB:JDO_DATA_LSB];
    end
    if (strobe_drop) begin
      err_d = 1'b1;
    end

    // The RAM strobes are registered, so they are loaded on the edge into ACC.
    // last_q names the owner of the access that is currently in flight.
    unique case (state_q)
      ST_IDLE: begin
        if (req_j || req_c) begin
          state_d = ST_ACC;
          last_d  = arb_gnt;
          if (arb_gnt == GNT_JTAG) begin
            ram_addr_d  = jaddr_q;
            ram_we_d    = jwr_q;
            ram_wdata_d = jwdata_q;
          end else begin
            ram_addr_d  = cpu_addr;
            ram_we_d    = cpu_we;
            ram_wdata_d = cpu_wdata;
            cpu_ack_d   = cpu_we;
          end
        end
      end
      ST_ACC: begin
        if (ram_we_q) begin
          state_d = ST_IDLE;
          if (last_q == GNT_JTAG) begin
            jpend_d = 1'b0;
            jaddr_d = jaddr_q + ADDR_W'(1);
          end
        end else begin
          state_d = ST_CAP;
        end
      end
      ST_CAP: begin
        state_d = ST_IDLE;
        if (last_q == GNT_JTAG) begin
          mondreg_d = ram_rdata;
          jpend_d   = 1'b0;
          jaddr_d   = jaddr_q + ADDR_W'(1);
        end else begin
          cpu_rdata_d = ram_rdata;
          cpu_ack_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) assignments only, so every
  // flop samples its pre-edge value no matter what order the statements run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      last_q      <= GNT_CPU;
      jpend_q     <= 1'b0;
      jaddr_q     <= '0;
      jwr_q       <= 1'b0;
      jwdata_q    <= '0;
      mondreg_q   <= '0;
      err_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      jpend_q     <= jpend_d;
      jaddr_q     <= jaddr_d;
      jwr_q       <= jwr_d;
      jwdata_q    <= jwdata_d;
      mondreg_q   <= mondreg_d;
      err_q       <= err_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign cpu_ack       = cpu_ack_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign ram_addr      = ram_addr_q;
  assign ram_we        = ram_we_q;
  assign ram_wdata     = ram_wdata_q;
  assign MonDReg       = mondreg_q;
  assign monitor_ready = ~jpend_q;
  assign monitor_error = err_q;

endmodule

// File: tb/tb_oci_action_sequencer.sv
// Directed bench for oci_action_sequencer: a table of JTAG/CPU accesses plus
// hand-written sequences for overrun, arbitration order and reset in flight.
module tb_oci_action_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b;
  logic        cpu_req, cpu_we;
  logic [7:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int n_chk  = 0;
  int n_pass = 0;
  int acc_cnt = 0;

`ifdef OCI_SEQ_JTAG_PRIORITY_EN
  localparam bit JPRIO = 1'b1;
`else
  localparam bit JPRIO = 1'b0;
`endif

  always #5 clk = ~clk;

  oci_action_sequencer dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .jdo                  (jdo),
    .take_action_ocimem_a (take_action_ocimem_a),
    .take_action_ocimem_b (take_action_ocimem_b),
    .cpu_req              (cpu_req),
    .cpu_we               (cpu_we),
    .cpu_addr             (cpu_addr),
    .cpu_wdata            (cpu_wdata),
    .cpu_ack              (cpu_ack),
    .cpu_rdata            (cpu_rdata),
    .ram_addr             (ram_addr),
    .ram_we               (ram_we),
    .ram_wdata            (ram_wdata),
    .ram_rdata            (ram_rdata),
    .MonDReg              (MonDReg),
    .monitor_ready        (monitor_ready),
    .monitor_error        (monitor_error)
  );

  // Single-port RAM with one-cycle read latency.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Access cycles observed: the DUT holds ram_addr at zero outside ACC.
  always @(posedge clk) begin
    if (ram_addr != 8'h00) acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          jtag;
    bit          we;
    bit          use_a;
    bit          same;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[17:10] = a;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic we, input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[35] = we;
    j[34:3] = d;
    return j;
  endfunction

  task automatic do_jtag(input vec_t v);
    if (v.use_a && !v.same) begin
      jdo = jdo_a(v.addr);
      take_action_ocimem_a = 1'b1;
      tick();
      take_action_ocimem_a = 1'b0;
    end
    if (v.same) begin
      jdo = jdo_a(v.addr);
      take_action_ocimem_a = 1'b1;
    end else begin
      jdo = jdo_b(v.we, v.wdata);
    end
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    check("j_pending_ready", 32'(monitor_ready), 32'd0);
    tick();
    check("j_acc_we", 32'(ram_we), 32'(v.we));
    check("j_acc_addr", 32'(ram_addr), 32'(v.addr));
    if (v.we) check("j_acc_wdata", ram_wdata, v.wdata);
    tick();
    check("j_cyc3_ready", 32'(monitor_ready), 32'(v.we));
    if (!v.we) begin
      tick();
      check("j_cyc4_ready", 32'(monitor_ready), 32'd1);
      check("j_mondreg", MonDReg, v.exp);
    end
  endtask

  task automatic do_cpu(input vec_t v);
    cpu_req = 1'b1;
    cpu_we = v.we;
    cpu_addr = v.addr;
    cpu_wdata = v.wdata;
    tick();
    check("c_acc_addr", 32'(ram_addr), 32'(v.addr));
    check("c_acc_we", 32'(ram_we), 32'(v.we));
    check("c_acc_ack", 32'(cpu_ack), 32'(v.we));
    if (v.we) begin
      check("c_acc_wdata", ram_wdata, v.wdata);
      cpu_req = 1'b0;
      tick();
      check("c_ack_pulse", 32'(cpu_ack), 32'd0);
    end else begin
      tick();
      check("c_cap_ack", 32'(cpu_ack), 32'd0);
      tick();
      check("c_rd_ack", 32'(cpu_ack), 32'd1);
      check("c_rdata", cpu_rdata, v.exp);
      cpu_req = 1'b0;
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, ram_wdata, 32'd0);
    check({tag, "_mondreg"}, MonDReg, 32'd0);
    check({tag, "_ready"}, 32'(monitor_ready), 32'd1);
    check({tag, "_error"}, 32'(monitor_error), 32'd0);
  endtask

  initial begin
    int base;
    logic [7:0] exp_first, exp_second;

    vt[0]  = '{1, 1, 1, 0, 8'h10, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1, 1, 0, 0, 8'h11, 32'h11111111, 32'h0};
    vt[2]  = '{1, 0, 1, 1, 8'h10, 32'h0,        32'hDEADBEEF};
    vt[3]  = '{1, 0, 0, 0, 8'h11, 32'h0,        32'h11111111};
    vt[4]  = '{0, 1, 0, 0, 8'h33, 32'h12345678, 32'h0};
    vt[5]  = '{0, 0, 0, 0, 8'h33, 32'h0,        32'h12345678};
    vt[6]  = '{1, 0, 1, 1, 8'h33, 32'h0,        32'h12345678};
    vt[7]  = '{0, 1, 0, 0, 8'h40, 32'h4040CAFE, 32'h0};
    vt[8]  = '{1, 1, 1, 0, 8'h00, 32'h0BADF00D, 32'h0};
    vt[9]  = '{1, 1, 1, 0, 8'hFF, 32'hA5A5A5A5, 32'h0};
    vt[10] = '{1, 0, 0, 0, 8'h00, 32'h0,        32'h0BADF00D};
    vt[11] = '{0, 0, 0, 0, 8'hFF, 32'h0,        32'hA5A5A5A5};
    vt[12] = '{0, 0, 0, 0, 8'h10, 32'h0,        32'hDEADBEEF};

    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      if (vt[i].jtag) do_jtag(vt[i]);
      else do_cpu(vt[i]);
    end

    // A second _b while a read is pending is dropped and flags an overrun.
    jdo = jdo_a(8'h40);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    base = acc_cnt;
    jdo = jdo_b(1'b0, 32'h0);
    take_action_ocimem_b = 1'b1;
    tick();
    check("ovr_err_before", 32'(monitor_error), 32'd0);
    jdo = jdo_b(1'b1, 32'h77777777);
    tick();
    take_action_ocimem_b = 1'b0;
    check("ovr_err_set", 32'(monitor_error), 32'd1);
    tick();
    tick();
    check("ovr_ready", 32'(monitor_ready), 32'd1);
    check("ovr_mondreg", MonDReg, 32'h4040CAFE);
    repeat (3) tick();
    check("ovr_one_access", 32'(acc_cnt - base), 32'd1);
    check("ovr_err_sticky", 32'(monitor_error), 32'd1);
    jdo = jdo_a(8'h50);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    check("ovr_err_cleared", 32'(monitor_error), 32'd0);

    // Contention: last grant is CPU after reset, so J,C,J,C in both builds.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    jdo = jdo_a(8'h20);
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
    jdo = jdo_b(1'b1, 32'hA0000001);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 8'h80;
    cpu_wdata = 32'hC0000001;
    tick();
    check("arb_g1_jtag", 32'(ram_addr), 32'h20);
    tick();
    check("arb_ready_after_j", 32'(monitor_ready), 32'd1);
    jdo = jdo_b(1'b1, 32'hA0000002);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    check("arb_g2_cpu", 32'(ram_addr), 32'h80);
    check("arb_g2_ack", 32'(cpu_ack), 32'd1);
    cpu_addr = 8'h81;
    cpu_wdata = 32'hC0000002;
    tick();
    tick();
    check("arb_g3_jtag", 32'(ram_addr), 32'h21);
    tick();
    tick();
    check("arb_g4_cpu", 32'(ram_addr), 32'h81);
    check("arb_g4_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick();
    jdo = jdo_b(1'b1, 32'hA0000003);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    tick();
    check("arb_j_alone", 32'(ram_addr), 32'h22);
    tick();
    jdo = jdo_b(1'b1, 32'hA0000004);
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
    cpu_req = 1'b1;
    cpu_addr = 8'h82;
    cpu_wdata = 32'hC0000003;
    // Both request with last grant = JTAG: round-robin picks CPU, priority picks JTAG.
    exp_first  = JPRIO ? 8'h23 : 8'h82;
    exp_second = JPRIO ? 8'h82 : 8'h23;
    tick();
    check("arb_g5_first", 32'(ram_addr), 32'(exp_first));
    if (cpu_ack) cpu_req = 1'b0;
    tick();
    tick();
    check("arb_g6_second", 32'(ram_addr), 32'(exp_second));
    if (cpu_ack) cpu_req = 1'b0;
    tick();
    check("arb_drained_req", 32'(cpu_req), 32'd0);
    check("arb_drained_ready", 32'(monitor_ready), 32'd1);

    // Reset asserted while a CPU read sits in CAP aborts it without an ack.
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 8'h33;
    tick();
    check("rcap_acc_addr", 32'(ram_addr), 32'h33);
    tick();
    reset_n = 1'b0;
    tick();
    check_reset_outputs("rcap");
    reset_n = 1'b1;
    cpu_req = 1'b0;
    tick();
    check("rcap_no_late_ack", 32'(cpu_ack), 32'd0);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 8'h05;
    cpu_wdata = 32'h55555555;
    tick();
    check("rcap_idle_we", 32'(ram_we), 32'd1);
    check("rcap_idle_addr", 32'(ram_addr), 32'h05);
    check("rcap_idle_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
